// File: rtl/neg_out_encoder_4x2_pkg.sv
// enc_pkg -- shared types and sizes for the negative-output 4-to-2 encoder.
//   state_e : FIFO occupancy states (EMPTY, ONE, TWO)
//   entry_t : one queued result, packed as {code, err}
//   CODE_W, LINES, DEPTH, CNT_W : code width, input lines, FIFO depth, counter width
package enc_pkg;

   localparam int CODE_W = 2;
   localparam int LINES  = 4;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              err;
   } entry_t;

endpackage

// File: rtl/neg_out_encoder_4x2_if.sv
// neg_out_encoder_4x2_if -- producer/consumer bundle for the encoder.
//   in_valid/in_ready/in_en/in_n     : sample input handshake plus active-low lines
//   out_valid/out_ready/out_code/out_err : head-of-queue result handshake
//   err_count                         : saturating count of accepted error patterns
// The master modport is the environment (producer and consumer); the slave
// modport is the encoder itself.
interface neg_out_encoder_4x2_if;
   import enc_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_en;
   logic [LINES-1:0]  in_n;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic              out_err;
   logic [CNT_W-1:0]  err_count;

   modport master (
      output in_valid, in_en, in_n, out_ready,
      input  in_ready, out_valid, out_code, out_err, err_count
   );

   modport slave (
      input  in_valid, in_en, in_n, out_ready,
      output in_ready, out_valid, out_code, out_err, err_count
   );

endinterface

// File: rtl/neg_out_encoder_4x2_prio.sv
// neg_prio_enc4 -- combinational active-low line encoder.
//   in_n : active-low lines, bit i low means line i asserted
//   code : index of the highest asserted line (0 when none asserted)
//   err  : set unless exactly one line is asserted
module neg_prio_enc4
   import enc_pkg::*;
(
   input  logic [LINES-1:0]  in_n,
   output logic [CODE_W-1:0] code,
   output logic              err
);

   logic [LINES-1:0] low;

   // Ascending scan so the last hit, i.e. the highest asserted line, wins.
   // Clearing the lowest set bit leaves something behind only when two or
   // more lines are asserted.
   always_comb begin
      low  = ~in_n;
      code = '0;
      for (int i = 0; i < LINES; i++) begin
         if (low[i]) begin
            code = CODE_W'(i);
         end
      end
      err = (low == '0) || ((low & (low - LINES'(1))) != '0);
   end

endmodule

// File: rtl/neg_out_encoder_4x2.sv
// neg_out_encoder_4x2 -- encodes active-low line samples and queues the
// results in a 2-entry FIFO.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, empties the queue and clears err_count
//   bus : slave side of neg_out_encoder_4x2_if (input sample, head result, err_count)
module neg_out_encoder_4x2
   import enc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   neg_out_encoder_4x2_if.slave  bus
);

   logic [CODE_W-1:0] enc_code;
   logic              enc_err;

   state_e            state_q, state_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [CNT_W-1:0]  err_count_q, err_count_d;

   logic              in_ready;
   logic              push;
   logic              pop;
   entry_t            head;

   neg_prio_enc4 u_prio (
      .in_n (bus.in_n),
      .code (enc_code),
      .err  (enc_err)
   );

   // Handshake decode. A full queue still takes a sample when the head leaves
   // on the same edge. Samples with in_en low complete the handshake but are
   // simply dropped.
   always_comb begin
      in_ready = (state_q != TWO) || bus.out_ready;
      push     = bus.in_valid && in_ready && bus.in_en;
      pop      = (state_q != EMPTY) && bus.out_ready;
   end

   // Next-state logic for occupancy, pointers, storage and error counter.
   // When full with push and pop together, wr_ptr equals rd_ptr: the slot being
   // vacated by the head is exactly the one refilled, so order is preserved.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_d       = mem_q;
      err_count_d = err_count_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{code: enc_code, err: enc_err};
         wr_ptr_d        = ~wr_ptr_q;
         if (enc_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10: begin
            case (state_q)
               EMPTY:   state_d = ONE;
               default: state_d = TWO;
            endcase
         end
         2'b01: begin
            case (state_q)
               TWO:     state_d = ONE;
               default: state_d = EMPTY;
            endcase
         end
         default: state_d = state_q;
      endcase
   end

   // State register; reset discards everything queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         mem_q       <= '{default: '0};
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
         err_count_q <= err_count_d;
      end
   end

   // Head result is forced to zero while the queue is empty so stale storage
   // never shows on the outputs.
   assign head          = mem_q[rd_ptr_q];
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_code  = (state_q != EMPTY) ? head.code : '0;
   assign bus.out_err   = (state_q != EMPTY) ? head.err  : 1'b0;
   assign bus.err_count = err_count_q;

endmodule
